// File: rtl/cpu_cache_rd_arb.sv
// cpu_cache_rd_arb: shares the cpu_cache read-request channel between LP0 and
// LP1, tags requests with lp_id, steers tagged responses back to their issuer,
// enforces per-requester outstanding-read credits and provides a flush/drain
// state machine that quiesces the read path on demand.
//
// Handshake rule (both channels): a transfer happens in a cycle where valid
// and ready are both high; a valid request is never withdrawn and its address
// and id stay stable until accepted.
//
// Optional build macro CPU_CACHE_RD_ARB_FIXED_PRIO_EN: when defined, LP0 wins
// every contested cycle instead of round-robin. Lock and credits are unchanged.
//
// dbg_state exposes the flush FSM state (0 RUN, 1 DRAIN, 2 DONE) for checkers.
module cpu_cache_rd_arb #(
  parameter int AWIDTH    = 10,
  parameter int LANES     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0][AWIDTH-1:0] i_rq_addr,
  input  logic [1:0]             i_rq_valid,
  output logic [1:0]             o_rq_ready,
  output logic [LANES-1:0][31:0] o_rs_data,
  output logic [1:0]             o_rs_valid,
  input  logic [1:0]             i_rs_ready,
  output logic [AWIDTH-1:0]      c_rdreq_addr,
  output logic                   c_rdreq_valid,
  output logic                   c_rdreq_lp_id,
  input  logic                   c_rdreq_ready,
  input  logic [LANES-1:0][31:0] c_rdresp_data,
  input  logic                   c_rdresp_valid,
  input  logic                   c_rdresp_lp_id,
  output logic                   c_rdresp_ready,
  input  logic                   i_flush_req,
  output logic                   o_flush_done,
  output logic [1:0][3:0]        o_outst,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t          state;
  logic [1:0][3:0] cnt;
  logic [1:0][3:0] cnt_nxt;
  logic            lock;
  logic            lock_id;
  logic            lock_nxt;
  logic [1:0]      elig;
  logic            gnt_valid;
  logic            gnt_id;
  logic            both_pick;
  logic            req_acc;
  logic            rsp_acc;
  logic [1:0]      inc;
  logic [1:0]      dec;

  // A requester may compete only with credit left and only while running
  always_comb begin
    elig = 2'b00;
    for (int k = 0; k < 2; k++) begin
      elig[k] = i_rq_valid[k] && (cnt[k] < MAX_CNT) && (state == ST_RUN);
    end
  end

`ifdef CPU_CACHE_RD_ARB_FIXED_PRIO_EN
  assign both_pick = 1'b0;
`else
  logic last;

  // Remember the most recent accepted winner; the other side gets priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (req_acc) begin
      last <= gnt_id;
    end
  end

  assign both_pick = ~last;
`endif

  // Grant select: a stalled request owns the channel until it is accepted
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (lock) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id;
    end else if (elig == 2'b11) begin
      gnt_valid = 1'b1;
      gnt_id    = both_pick;
    end else if (elig[0]) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (elig[1]) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  assign c_rdreq_valid = gnt_valid;
  assign c_rdreq_addr  = i_rq_addr[gnt_id];
  assign c_rdreq_lp_id = gnt_id;
  assign o_rq_ready[0] = gnt_valid & ~gnt_id & c_rdreq_ready;
  assign o_rq_ready[1] = gnt_valid &  gnt_id & c_rdreq_ready;
  assign req_acc       = gnt_valid & c_rdreq_ready;
  assign lock_nxt      = gnt_valid & ~c_rdreq_ready;

  assign o_rs_data      = c_rdresp_data;
  assign o_rs_valid[0]  = c_rdresp_valid & ~c_rdresp_lp_id;
  assign o_rs_valid[1]  = c_rdresp_valid &  c_rdresp_lp_id;
  assign c_rdresp_ready = i_rs_ready[c_rdresp_lp_id];
  assign rsp_acc        = c_rdresp_valid & c_rdresp_ready;

  // Next credit counts: +1 per accepted request, -1 per accepted response
  always_comb begin
    inc     = 2'b00;
    dec     = 2'b00;
    cnt_nxt = cnt;
    for (int k = 0; k < 2; k++) begin
      inc[k] = req_acc && (gnt_id == 1'(k));
      dec[k] = rsp_acc && (c_rdresp_lp_id == 1'(k));
      if (inc[k] && !dec[k]) begin
        cnt_nxt[k] = cnt[k] + 4'd1;
      end else if (!inc[k] && dec[k] && (cnt[k] != 4'd0)) begin
        cnt_nxt[k] = cnt[k] - 4'd1;
      end
    end
  end

  // Credit counters and the stall lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      lock    <= lock_nxt;
      lock_id <= gnt_id;
    end
  end

  // Flush FSM; DONE is judged on next-cycle credits so it follows the last
  // accepted response by exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      o_flush_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          o_flush_done <= 1'b0;
          if (i_flush_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!i_flush_req) begin
            state        <= ST_RUN;
            o_flush_done <= 1'b0;
          end else if ((cnt_nxt[0] == 4'd0) && (cnt_nxt[1] == 4'd0) && !lock_nxt) begin
            state        <= ST_DONE;
            o_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!i_flush_req) begin
            state        <= ST_RUN;
            o_flush_done <= 1'b0;
          end
        end
        default: begin
          state        <= ST_RUN;
          o_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_outst   = cnt;
  assign dbg_state = state;

  // A response for a requester with no reads in flight is a cache protocol error
  a_no_underflow_0: assert property (@(posedge clk) disable iff (reset)
    !(dec[0] && !inc[0] && (cnt[0] == 4'd0)));
  a_no_underflow_1: assert property (@(posedge clk) disable iff (reset)
    !(dec[1] && !inc[1] && (cnt[1] == 4'd0)));

endmodule
